// File: rtl/lsu_dbus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_dbus_ctrl
// Description : Load/store sequencer between EX and the single-port data bus.
//               Turns one load/store into a word-aligned bus request with
//               byte enables and lane-replicated store data. Runs the
//               req/gnt/rvalid handshake and stalls the pipeline while busy.
//               Flags misaligned ops, bus errors and response timeouts.
// Ports       :
//   clk, rst_n             clock, asynchronous active-low reset
//   lsu_valid_i            EX presents a memory op
//   lsu_is_load_i          1 = load, 0 = store
//   lsu_size_i             00 byte, 01 half, 10 word, 11 reserved
//   lsu_addr_i/wdata_i     byte address, right-justified store data
//   flush_i                pipeline flush
//   lsu_stall_o            hold EX/MEM pipeline registers
//   lsu_done_o             completion pulse, lsu_rdata_o/lsu_addr_2low_o valid
//   lsu_misalign_o         misaligned-op rejection pulse
//   lsu_err_o              bus error or timeout pulse
//   dbus_*                 data bus request/response interface
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dbus_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_valid_i,
    input  logic            lsu_is_load_i,
    input  logic [1:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            flush_i,
    output logic            lsu_stall_o,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic [1:0]      lsu_addr_2low_o,
    output logic            lsu_misalign_o,
    output logic            lsu_err_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    input  logic            dbus_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // Last counter value of the RSP window; reaching it ends the wait.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [1:0]        r_addr_2low;
    logic              r_kill,     w_kill_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_err,      w_err_nxt;
    logic              r_misalign;
    logic [XLEN-1:0]   r_rdata;
    logic [1:0]        r_rdata_2low;

    logic              w_misalign;
    logic              w_accept;
    logic              w_reject;
    logic [3:0]        w_be_new;
    logic [XLEN-1:0]   w_wdata_new;

    // ------------------------------------------------------------------
    // Decode of the op presented by EX
    // ------------------------------------------------------------------
    always_comb begin
        w_misalign  = 1'b0;
        w_be_new    = 4'b1111;
        w_wdata_new = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                w_misalign  = 1'b0;
                w_be_new    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata_new = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                w_misalign  = lsu_addr_i[0];
                w_be_new    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata_new = {2{lsu_wdata_i[15:0]}};
            end
            2'b10: begin
                w_misalign  = |lsu_addr_i[1:0];
            end
            default: begin
                w_misalign  = 1'b1;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && lsu_valid_i && !w_misalign && !flush_i;
    assign w_reject = (r_state == S_IDLE) && lsu_valid_i &&  w_misalign && !flush_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and pulse decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_kill_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (dbus_gnt_i) begin
                    // The bus owns the transfer once granted, so a flush in
                    // the grant cycle can only suppress its result.
                    w_state_nxt = S_RSP;
                    w_cnt_nxt   = '0;
                    w_kill_nxt  = flush_i;
                end else if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RSP: begin
                if (flush_i) begin
                    w_kill_nxt = 1'b1;
                end
                if (dbus_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                    w_kill_nxt  = 1'b0;
                    if (!(r_kill || flush_i)) begin
                        w_err_nxt  = dbus_err_i;
                        w_done_nxt = !dbus_err_i;
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_IDLE;
                    w_kill_nxt  = 1'b0;
                    w_err_nxt   = !(r_kill || flush_i);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched op, control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_addr_2low  <= 2'b00;
            r_kill       <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_misalign   <= 1'b0;
            r_rdata      <= '0;
            r_rdata_2low <= 2'b00;
        end else begin
            if (w_accept) begin
                r_we        <= !lsu_is_load_i;
                r_addr      <= {lsu_addr_i[XLEN-1:2], 2'b00};
                r_be        <= w_be_new;
                r_wdata     <= w_wdata_new;
                r_addr_2low <= lsu_addr_i[1:0];
            end
            r_kill     <= w_kill_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_misalign <= w_reject;
            if (w_done_nxt) begin
                r_rdata      <= r_we ? '0 : dbus_rdata_i;
                r_rdata_2low <= r_addr_2low;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The misalign pulse cycle stalls so the exception can be taken before
    // the next instruction advances out of EX.
    assign lsu_stall_o     = (r_state != S_IDLE) || w_accept || r_misalign;
    assign lsu_done_o      = r_done;
    assign lsu_err_o       = r_err;
    assign lsu_misalign_o  = r_misalign;
    assign lsu_rdata_o     = r_rdata;
    assign lsu_addr_2low_o = r_rdata_2low;
    assign dbus_req_o      = (r_state == S_REQ);
    assign dbus_we_o       = r_we;
    assign dbus_addr_o     = r_addr;
    assign dbus_be_o       = r_be;
    assign dbus_wdata_o    = r_wdata;

endmodule
`default_nettype wire
